mem_ctrl: RTL

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_pkg.sv | 25 ++
 rtl/mem_bank.sv | 43 ++++
 rtl/mem_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: types and constants shared by the memory controller slice.
//   state_t    - controller FSM states (IDLE, ACCESS, CAPTURE, REPLY)
//   op_t       - operation being serviced (OP_RD, OP_WR)
//   slot_width - width of one stored slot: data word plus one spare bit
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_CAPTURE,
        ST_REPLY
    } state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } op_t;

    localparam int unsigned SPARE_BITS = 1;

    function automatic int unsigned slot_width(input int unsigned word_w);
        return word_w + SPARE_BITS;
    endfunction

endpackage

// File: rtl/mem_bank.sv
// mem_bank: behavioural single-port SRAM, LINES x LINE_W, one-cycle read.
// Ports (all control active-low):
//   i_clk   - clock, rising edge
//   i_cen   - chip enable (0 = access this cycle)
//   i_wen   - write enable (0 = write, 1 = read)
//   i_bwen  - per-bit write enable (0 = bit written)
//   i_addr  - line address
//   i_d     - write line
//   o_q     - read line, valid the cycle after a read access
// Contents are not reset.
module mem_bank #(
    parameter int unsigned LINES  = 128,
    parameter int unsigned LINE_W = 128,
    parameter int unsigned AW     = $clog2(LINES)
) (
    input  logic              i_clk,
    input  logic              i_cen,
    input  logic              i_wen,
    input  logic [LINE_W-1:0] i_bwen,
    input  logic [AW-1:0]     i_addr,
    input  logic [LINE_W-1:0] i_d,
    output logic [LINE_W-1:0] o_q
);

    logic [LINE_W-1:0] r_mem [LINES];
    logic [LINE_W-1:0] r_q;
    logic [LINE_W-1:0] w_bit_we;

    assign w_bit_we = ~i_bwen;

    always_ff @(posedge i_clk) begin
        if (!i_cen) begin
            if (!i_wen) begin
                r_mem[i_addr] <= (r_mem[i_addr] & ~w_bit_we) | (i_d & w_bit_we);
            end else begin
                r_q <= r_mem[i_addr];
            end
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: banked SRAM controller with one write and one read channel.
// Each channel latches its request into a pending slot; the FSM services one
// pending operation at a time (write first) through IDLE->ACCESS->CAPTURE->REPLY.
// Ports:
//   clk, resetn        - clock (rising edge), synchronous active-low reset
//   wr_req/addr/data   - write request pulse with its address and word
//   rd_req/addr        - read request pulse with its address
//   rd_data            - last read word, held until the next read reply
//   rd_reply, wr_reply - one-cycle completion pulses
//   busy               - FSM active or any request pending
//   par_err            - parity mismatch pulse alongside rd_reply
// Build option: MEM_PARITY_EN stores even parity in each slot's spare bit and
// checks it on read; otherwise the spare bit is written 0 and par_err is 0.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned WORD_W = 31,
    parameter int unsigned BANKS  = 8,
    parameter int unsigned LINES  = 128,
    parameter int unsigned WPL    = 4,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_reply,
    output logic              wr_reply,
    output logic              busy,
    output logic              par_err
);

    localparam int unsigned BANK_W  = $clog2(BANKS);
    localparam int unsigned LINE_AW = $clog2(LINES);
    localparam int unsigned SLOT_AW = $clog2(WPL);
    localparam int unsigned SLOT_W  = slot_width(WORD_W);
    localparam int unsigned LINE_W  = WPL * SLOT_W;
    localparam int unsigned IDX_W   = $clog2(LINE_W);

    // Defaults give a 12-bit word address over 8 x 128 x 4 words.
    if (ADDR_W != $clog2(BANKS * LINES * WPL)) begin : g_addr_w_check
        $error("mem_ctrl: ADDR_W must equal clog2(BANKS*LINES*WPL)");
    end

    state_t              r_state;
    state_t              w_next;
    op_t                 r_op;
    logic                r_wr_pend;
    logic                r_rd_pend;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [WORD_W-1:0]   r_wr_data;
    logic [WORD_W-1:0]   r_rd_data;

    logic [ADDR_W-1:0]   w_addr;
    logic [BANK_W-1:0]   w_bank;
    logic [LINE_AW-1:0]  w_line;
    logic [SLOT_AW-1:0]  w_slot;
    logic [IDX_W-1:0]    w_slot_base;
    logic [SLOT_W-1:0]   w_wr_slot;
    logic [LINE_W-1:0]   w_wr_line;
    logic [LINE_W-1:0]   w_bwen;
    logic [LINE_W-1:0]   w_q [BANKS];
    logic [LINE_W-1:0]   w_line_q;
    logic [BANKS-1:0]    w_cen;
    logic                w_wen;
    logic [WORD_W-1:0]   w_rd_word;

    // r_op is stable from ACCESS through REPLY, so it picks the live address.
    assign w_addr      = (r_op == OP_WR) ? r_wr_addr : r_rd_addr;
    assign w_bank      = w_addr[ADDR_W-1 -: BANK_W];
    assign w_line      = w_addr[ADDR_W-BANK_W-1 -: LINE_AW];
    assign w_slot      = w_addr[SLOT_AW-1:0];
    assign w_slot_base = IDX_W'(w_slot * SLOT_W);

`ifdef MEM_PARITY_EN
    assign w_wr_slot = {^r_wr_data, r_wr_data};
`else
    assign w_wr_slot = {1'b0, r_wr_data};
`endif

    // Replicate the slot across the line; the bit mask confines the write.
    assign w_wr_line = {WPL{w_wr_slot}};
    assign w_bwen    = ~({{(LINE_W-SLOT_W){1'b0}}, {SLOT_W{1'b1}}} << w_slot_base);
    assign w_wen     = (r_op != OP_WR);

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        assign w_cen[b] = !((r_state == ST_ACCESS) && (w_bank == BANK_W'(b)));

        mem_bank #(
            .LINES  (LINES),
            .LINE_W (LINE_W),
            .AW     (LINE_AW)
        ) u_bank (
            .i_clk  (clk),
            .i_cen  (w_cen[b]),
            .i_wen  (w_wen),
            .i_bwen (w_bwen),
            .i_addr (w_line),
            .i_d    (w_wr_line),
            .o_q    (w_q[b])
        );
    end

    assign w_line_q  = w_q[w_bank];
    assign w_rd_word = w_line_q[w_slot_base +: WORD_W];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        rd_reply = 1'b0;
        wr_reply = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (r_wr_pend || r_rd_pend) begin
                    w_next = ST_ACCESS;
                end
            end
            ST_ACCESS:  w_next = ST_CAPTURE;
            ST_CAPTURE: w_next = ST_REPLY;
            ST_REPLY: begin
                w_next = ST_IDLE;
                if (r_op == OP_WR) begin
                    wr_reply = 1'b1;
                end else begin
                    rd_reply = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // A request while its own channel is pending is dropped; since the flag
    // is still set during REPLY, set and clear never collide.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_pend <= 1'b0;
            r_rd_pend <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_rd_addr <= '0;
            r_rd_data <= '0;
            r_op      <= OP_RD;
        end else begin
            if (wr_req && !r_wr_pend) begin
                r_wr_pend <= 1'b1;
                r_wr_addr <= wr_addr;
                r_wr_data <= wr_data;
            end else if (r_state == ST_REPLY && r_op == OP_WR) begin
                r_wr_pend <= 1'b0;
            end

            if (rd_req && !r_rd_pend) begin
                r_rd_pend <= 1'b1;
                r_rd_addr <= rd_addr;
            end else if (r_state == ST_REPLY && r_op == OP_RD) begin
                r_rd_pend <= 1'b0;
            end

            if (r_state == ST_IDLE) begin
                r_op <= r_wr_pend ? OP_WR : OP_RD;
            end

            if (r_state == ST_CAPTURE && r_op == OP_RD) begin
                r_rd_data <= w_rd_word;
            end
        end
    end

`ifdef MEM_PARITY_EN
    logic r_par_bad;
    logic w_rd_bad;

    assign w_rd_bad = w_line_q[w_slot_base + IDX_W'(WORD_W)] != ^w_rd_word;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_par_bad <= 1'b0;
        end else if (r_state == ST_CAPTURE && r_op == OP_RD) begin
            r_par_bad <= w_rd_bad;
        end
    end

    assign par_err = rd_reply && r_par_bad;
`else
    assign par_err = 1'b0;
`endif

    assign rd_data = r_rd_data;
    assign busy    = (r_state != ST_IDLE) || r_wr_pend || r_rd_pend;

endmodule
